sdram_write_feeder: RTL

- Upstream stage of the SDRAM write engine, on the Wishbone slave side.
- Accepts 32-bit Wishbone write cycles and packs each one into a 36-bit entry {mask[3:0], data[31:0]}.
- Buffers entries in an internal FIFO and presents them on the engine's FIFO port (fifo_data / fifo_empty / fifo_rd).
- Drives the engine's en and start address, and closes a burst when the Wishbone address breaks sequence or the cycle ends.

---
 rtl/sdram_write_feeder_pkg.sv | 20 ++
 rtl/sdram_wr_fifo.sv | 46 ++++
 rtl/sdram_write_feeder.sv | 102 ++++++++++
 3 files changed

// File: rtl/sdram_write_feeder_pkg.sv
// sdram_write_feeder_pkg: shared state encoding and FIFO entry layout for the SDRAM write feeder
package sdram_write_feeder_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    DRAIN    = 2'd2,
    WAIT_RDY = 2'd3
  } state_t;
  localparam int ENTRY_W  = 36;
  localparam int MASK_MSB = 35;
  localparam int MASK_LSB = 32;
  // A mask bit of 1 blocks its byte, so the Wishbone byte selects are inverted.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [3:0] sel, input logic [31:0] dat);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[MASK_MSB:MASK_LSB] = ~sel;
    e[31:0] = dat;
    return e;
  endfunction
endpackage

// File: rtl/sdram_wr_fifo.sv
// sdram_wr_fifo: synchronous 2**DEPTH_LOG2-entry FIFO with registered pop output
// Ports: push_i/din_i write side; pop_i pops the head into dout_o on the same edge;
//        full_o/empty_o/level_o report occupancy. Async active-high reset clears pointers and dout_o.
module sdram_wr_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [W-1:0]          din_i,
  input  logic                  pop_i,
  output logic [W-1:0]          dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_q, rd_q;
  logic [W-1:0] dout_q;
  logic do_push, do_pop;
  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level_o = wr_q - rd_q;
  assign full_o  = level_o == DEPTH[DEPTH_LOG2:0];
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = dout_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        dout_q <= mem[rd_q[DEPTH_LOG2-1:0]];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[DEPTH_LOG2-1:0]] <= din_i;
  end
endmodule

// File: rtl/sdram_write_feeder.sv
// sdram_write_feeder: packs Wishbone writes into {mask,data} entries and feeds the SDRAM write engine
// Ports: i_wbs_* Wishbone slave (writes only), o_wbs_ack single-cycle ack;
//        en/address/ready engine handshake; fifo_data/fifo_empty/fifo_rd/fifo_level engine FIFO port.
// Option: define SDRAM_WR_FEEDER_STATS_EN to add the saturating stall_count output.
module sdram_write_feeder
  import sdram_write_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_LSB   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wbs_cyc,
  input  logic                  i_wbs_stb,
  input  logic                  i_wbs_we,
  input  logic [3:0]            i_wbs_sel,
  input  logic [31:0]           i_wbs_adr,
  input  logic [31:0]           i_wbs_dat,
  output logic                  o_wbs_ack,
  output logic                  en,
  output logic [21:0]           address,
  input  logic                  ready,
`ifdef SDRAM_WR_FEEDER_STATS_EN
  output logic [15:0]           stall_count,
`endif
  output logic [ENTRY_W-1:0]    fifo_data,
  output logic                  fifo_empty,
  input  logic                  fifo_rd,
  output logic [DEPTH_LOG2:0]   fifo_level
);
  state_t state_q, state_d;
  logic [21:0] addr_q, addr_d, exp_q, exp_d;
  logic ack_q, en_q, en_d;
  logic [21:0] word;
  logic wr_req, rd_req, seq, accept, full;
  logic unused_adr;
  assign word       = i_wbs_adr[ADDR_LSB+21:ADDR_LSB];
  assign unused_adr = &{1'b0, i_wbs_adr};
  // While ack is high the master still shows the just-acked cycle, so it is not a new request.
  assign wr_req = i_wbs_cyc && i_wbs_stb && i_wbs_we && !ack_q;
  assign rd_req = i_wbs_cyc && i_wbs_stb && !i_wbs_we && !ack_q;
  assign seq    = word == exp_q;
  assign accept = wr_req && !full && (state_q == IDLE || (state_q == FILL && seq));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    exp_d   = exp_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = word;
        exp_d   = word + 22'd1;
        state_d = FILL;
      end
      FILL: begin
        if (!i_wbs_cyc || rd_req || (wr_req && !seq)) state_d = DRAIN;
        else if (accept) exp_d = exp_q + 22'd1;
      end
      DRAIN:    state_d = fifo_empty ? WAIT_RDY : DRAIN;
      WAIT_RDY: state_d = ready ? IDLE : WAIT_RDY;
    endcase
    en_d = state_d == FILL || state_d == DRAIN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      exp_q   <= '0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      exp_q   <= exp_d;
      ack_q   <= accept;
      en_q    <= en_d;
    end
  end
  assign o_wbs_ack = ack_q;
  assign en        = en_q;
  assign address   = addr_q;
  sdram_wr_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .din_i   (pack_entry(i_wbs_sel, i_wbs_dat)),
    .pop_i   (fifo_rd),
    .dout_o  (fifo_data),
    .full_o  (full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );
`ifdef SDRAM_WR_FEEDER_STATS_EN
  logic [15:0] stall_q;
  logic stall;
  assign stall = wr_req && (full || state_q == DRAIN || state_q == WAIT_RDY);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_count = stall_q;
`endif
endmodule
